pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the single-issue RV32I core.
- Sits directly downstream of the ALU: it takes the ALU comparison flag (branch condition) and the ALU result (JALR target) and computes the next PC.
- It fetches the next instruction over a req/ack handshake and presents it to the decoder. The decoder drives the ALU operation code and operands for that instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FETCH_TIMEOUT, 16, maximum number of cycles spent in FETCH without imem_ack before a timeout error. Legal range 2..255.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; registered.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction for the decoder.
- instr_valid  output  1  instr is held and awaiting execution.
- ex_done  input  1  execute stage has finished instr; branch inputs are valid this cycle.
- is_branch  input  1  instr is a conditional branch.
- is_jal  input  1  instr is JAL.
- is_jalr  input  1  instr is JALR.
- cmp_flag  input  1  ALU comparison result (1 = branch taken).
- alu_result  input  32  ALU output; JALR target (rs1+imm).
- imm  input  32  sign-extended immediate from the decoder.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc+4, for the link write-back.
- err  output  1  sticky error flag.
- err_code  output  2  01 = misaligned target, 10 = fetch timeout, 00 = none.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, err=0, err_code=00, timeout counter=0.
- Reset is honoured in any state, including mid-fetch or mid-execute. imem_req drops in the cycle after the reset edge; any pending ack is discarded.
- IDLE: lasts one cycle, then goes to FETCH and sets imem_req=1.
- FETCH: imem_req=1 and instr_valid=0.
  - On imem_ack=1 at a clock edge: instr<=imem_rdata, imem_req<=0, instr_valid<=1, go to EXEC, counter<=0.
  - An ack in the first FETCH cycle is legal.
  - Without ack: counter increments. When counter==FETCH_TIMEOUT-1 and there is still no ack: go to ERR with err_code=10.
- EXEC: instr_valid=1. On ex_done=1, compute next_pc with this priority:
  - is_jalr: {alu_result[31:1],1'b0}.
  - else is_jal: pc+imm.
  - else is_branch && cmp_flag: pc+imm.
  - else: pc+4.
  - All adds are mod 2^32; wrap-around is silent.
  - If next_pc[1]==1: go to ERR with err_code=01; pc is not updated.
  - Otherwise: pc<=next_pc, instr_valid<=0, imem_req<=1, go to FETCH.
- ERR: imem_req=0, instr_valid=0, err=1. pc and instr hold their values. The only exit is rst.
- Ignored inputs: imem_ack outside FETCH; ex_done outside EXEC; is_branch/is_jal/is_jalr/cmp_flag when ex_done=0.
- Combinational outputs: imem_addr=pc and pc_plus4=pc+4.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle, ex_done in the first EXEC cycle).

Test Plan:
- Reset/sequential fetch:
  - Stimulus: RESET_PC=0; ack in the first FETCH cycle; ex_done after 1 cycle, no branch flags.
  - Required: imem_addr runs 0,4,8,C; instr matches imem_rdata; a new imem_req every 2 cycles.
- Branch taken/not taken:
  - Stimulus: pc=0x100, imm=0xFFFFFFF0, is_branch=1.
  - Required: cmp_flag=1 gives next pc=0xF0; cmp_flag=0 gives next pc=0x104.
- JALR priority and alignment:
  - Stimulus: is_jalr=1 and is_jal=1, alu_result=0x2001.
  - Required: pc=0x2000 (JALR wins, bit0 cleared); no error.
- Misaligned target:
  - Stimulus: is_jal=1, pc=0x10, imm=0x6.
  - Required: err=1, err_code=01, pc stays 0x10, imem_req=0; recovers only after rst.
- Fetch timeout and reset mid-fetch:
  - Timeout stimulus: FETCH_TIMEOUT=4, no ack.
  - Timeout required: ERR entered after exactly 4 FETCH cycles, err_code=10.
  - Reset stimulus: a separate run with rst asserted in the 2nd FETCH cycle.
  - Reset required: imem_req=0 and pc=RESET_PC on the next cycle; a late ack is ignored.
- Wrap-around:
  - Stimulus: pc=0xFFFFFFFC, no branch.
  - Required: next pc=0x00000000, pc_plus4=0x0 while at 0xFFFFFFFC; no error.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC sequencer and instruction fetch for the single-issue RV32I core.
// Fetches over a req/ack handshake, holds the word for execute, then steps/jumps the PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        cmp_flag,
  input  logic [31:0] alu_result,
  input  logic [31:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_instr;
  logic        r_req, r_vld, r_err;
  logic [1:0]  r_code;
  logic [7:0]  r_cnt;

  logic [31:0] w_pc_plus4, w_pc_imm, w_next_pc;
  logic        w_to_hit;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_imm   = r_pc + imm;
  assign w_to_hit   = (r_cnt == TO_LAST);

  // JALR beats JAL beats a taken branch; everything else falls through.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (is_jalr)                          w_next_pc = alu_result & ~32'd1;
    else if (is_jal || (is_branch && cmp_flag)) w_next_pc = w_pc_imm;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)      w_state_nxt = S_EXEC;
        else if (w_to_hit) w_state_nxt = S_ERR;
      end
      S_EXEC:  if (ex_done) w_state_nxt = w_next_pc[1] ? S_ERR : S_FETCH;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_req   <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req <= 1'b1;
          r_cnt <= 8'd0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_vld   <= 1'b1;
            r_cnt   <= 8'd0;
          end else if (w_to_hit) begin
            r_req  <= 1'b0;
            r_err  <= 1'b1;
            r_code <= 2'b10;
            r_cnt  <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            r_vld <= 1'b0;
            // A misaligned target leaves pc pointing at the faulting instruction.
            if (w_next_pc[1]) begin
              r_err  <= 1'b1;
              r_code <= 2'b01;
            end else begin
              r_pc  <= w_next_pc;
              r_req <= 1'b1;
            end
          end
        end
        default: begin
          r_req <= 1'b0;
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_vld;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign err         = r_err;
  assign err_code    = r_code;

endmodule
